latch_bank_seq_checker: RTL and testbench



---
 rtl/latch_bank_seq_checker.sv | 185 ++++++++++++++++++
 tb/tb_latch_bank_seq_checker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/latch_bank_seq_checker.sv
// Stimulus generator and scoreboard for a 6-cell async-reset latch bank (PP/PN/NP x reset-to-0/1).
// Latency: done rises NUM_VECTORS+2 cycles after start; each applied vector is checked on the following edge.
// Backpressure: none; start is only accepted in IDLE/DONE. Optional first-fail log: LATCH_SEQ_ERRLOG_EN.
module latch_bank_seq_checker #(
    parameter int unsigned NUM_VECTORS = 64,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        C,
    input  logic        R,
    input  logic        start,
    output logic        LE,
    output logic        LR,
    output logic        LD,
    input  logic [5:0]  Q_i,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [15:0] first_fail_idx,
    output logic [5:0]  first_fail_q
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT1 = 3'd1;
    localparam logic [2:0] S_INIT2 = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] NV       = 16'(NUM_VECTORS);
    localparam logic [5:0]  RST_VAL  = 6'b111000;

    logic [2:0]  state_q, state_d;
    logic        le_q, le_d, lr_q, lr_d, ld_q, ld_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] vcnt_q, vcnt_d;
    logic [5:0]  exp_q, exp_d, known_q, known_d;
    logic [7:0]  err_q, err_d;

    logic        cmp_en, run_start, mismatch, lfsr_fb;
    logic [5:0]  rst_act, en_act, exp_mdl, known_mdl;

    // Model sees the vector currently on the bus, i.e. the registered drive values.
    // Bit order: [0]=PP0 [1]=PN0 [2]=NP0 [3]=PP1 [4]=PN1 [5]=NP1.
    always_comb begin
        rst_act   = {lr_q, ~lr_q, lr_q, lr_q, ~lr_q, lr_q};
        en_act    = {~le_q, le_q, le_q, ~le_q, le_q, le_q};
        exp_mdl   = (rst_act & RST_VAL) | (~rst_act & en_act & {6{ld_q}})
                  | (~rst_act & ~en_act & exp_q);
        known_mdl = known_q | rst_act | en_act;
        cmp_en    = (state_q == S_INIT1) || (state_q == S_INIT2)
                 || (state_q == S_RUN)   || (state_q == S_DRAIN);
        run_start = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
        mismatch  = cmp_en && (|((Q_i ^ exp_mdl) & known_mdl));
        lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    end

    always_comb begin
        state_d = state_q;
        le_d    = le_q;
        lr_d    = lr_q;
        ld_d    = ld_q;
        lfsr_d  = lfsr_q;
        vcnt_d  = vcnt_q;
        exp_d   = exp_q;
        known_d = known_q;
        err_d   = err_q;

        if (cmp_en) begin
            exp_d   = exp_mdl;
            known_d = known_mdl;
            if (mismatch && (err_q != 8'hFF)) begin
                err_d = err_q + 8'd1;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_INIT1;
                    {le_d, lr_d, ld_d} = 3'b010;
                    lfsr_d  = SEED_EFF;
                    vcnt_d  = '0;
                    exp_d   = '0;
                    known_d = '0;
                    err_d   = '0;
                end
            end
            S_INIT1: begin
                state_d = S_INIT2;
                {le_d, lr_d, ld_d} = 3'b100;
            end
            S_INIT2, S_RUN: begin
                // DRAIN is the cycle in which the final random vector sits on the bus.
                {le_d, lr_d, ld_d} = lfsr_q[2:0];
                lfsr_d  = {lfsr_q[14:0], lfsr_fb};
                vcnt_d  = vcnt_q + 16'd1;
                state_d = ((vcnt_q + 16'd1) == NV) ? S_DRAIN : S_RUN;
            end
            S_DRAIN: begin
                state_d = S_DONE;
                {le_d, lr_d, ld_d} = 3'b010;
            end
            default: begin
                state_d = S_IDLE;
                {le_d, lr_d, ld_d} = 3'b010;
            end
        endcase
    end

    always_ff @(posedge C) begin
        if (R) begin
            state_q <= S_IDLE;
            le_q    <= 1'b0;
            lr_q    <= 1'b1;
            ld_q    <= 1'b0;
            lfsr_q  <= SEED_EFF;
            vcnt_q  <= '0;
            exp_q   <= '0;
            known_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            le_q    <= le_d;
            lr_q    <= lr_d;
            ld_q    <= ld_d;
            lfsr_q  <= lfsr_d;
            vcnt_q  <= vcnt_d;
            exp_q   <= exp_d;
            known_q <= known_d;
            err_q   <= err_d;
        end
    end

`ifdef LATCH_SEQ_ERRLOG_EN
    logic [15:0] idx_q, idx_d, ffi_q, ffi_d;
    logic [5:0]  ffq_q, ffq_d;

    // err_q still zero means this is the first mismatching vector of the run.
    always_comb begin
        idx_d = idx_q;
        ffi_d = ffi_q;
        ffq_d = ffq_q;
        if (run_start) begin
            idx_d = '0;
            ffi_d = '0;
            ffq_d = '0;
        end else if (cmp_en) begin
            idx_d = idx_q + 16'd1;
            if (mismatch && (err_q == 8'd0)) begin
                ffi_d = idx_q;
                ffq_d = Q_i;
            end
        end
    end

    always_ff @(posedge C) begin
        if (R) begin
            idx_q <= '0;
            ffi_q <= '0;
            ffq_q <= '0;
        end else begin
            idx_q <= idx_d;
            ffi_q <= ffi_d;
            ffq_q <= ffq_d;
        end
    end

    assign first_fail_idx = ffi_q;
    assign first_fail_q   = ffq_q;
`else
    assign first_fail_idx = 16'd0;
    assign first_fail_q   = 6'd0;
`endif

    assign LE        = le_q;
    assign LR        = lr_q;
    assign LD        = ld_q;
    assign busy      = cmp_en;
    assign done      = (state_q == S_DONE);
    assign pass      = done && (err_q == 8'd0);
    assign err_count = err_q;

endmodule

// File: tb/tb_latch_bank_seq_checker.sv
// Directed bench: behavioural latch banks (ideal or faulted) wired around two checker instances.
module tb_latch_bank_seq_checker;

    logic        C = 1'b0;
    logic        R = 1'b1;
    logic        start = 1'b0;
    logic        start_s = 1'b0;
    logic [1:0]  fault = 2'd0;

    logic        LE, LR, LD, busy, done, pass;
    logic [7:0]  err_count;
    logic [15:0] first_fail_idx;
    logic [5:0]  first_fail_q, Q_i;

    logic        LE_s, LR_s, LD_s, busy_s, done_s, pass_s;
    logic [7:0]  err_s;
    logic [15:0] ffi_s;
    logic [5:0]  ffq_s, Q_s;

    logic [5:0]  bank = '0;
    logic [5:0]  bank_s = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 C = ~C;

    latch_bank_seq_checker #(.NUM_VECTORS(64)) u_dut (
        .C(C), .R(R), .start(start), .LE(LE), .LR(LR), .LD(LD), .Q_i(Q_i),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_idx(first_fail_idx), .first_fail_q(first_fail_q)
    );

    latch_bank_seq_checker #(.NUM_VECTORS(300)) u_sat (
        .C(C), .R(R), .start(start_s), .LE(LE_s), .LR(LR_s), .LD(LD_s), .Q_i(Q_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s),
        .first_fail_idx(ffi_s), .first_fail_q(ffq_s)
    );

    // Level-sensitive cells; inputs only move at posedge, so evaluating mid-cycle is exact.
    function automatic logic [5:0] bank_nx(input logic [5:0] q, input logic e, input logic r,
                                           input logic d, input logic pn_inv);
        logic [5:0] n;
        n = q;
        if (r) n[0] = 1'b0; else if (e) n[0] = d;
        if (pn_inv ? r : !r) n[1] = 1'b0; else if (e) n[1] = d;
        if (r) n[2] = 1'b0; else if (!e) n[2] = d;
        if (r) n[3] = 1'b1; else if (e) n[3] = d;
        if (!r) n[4] = 1'b1; else if (e) n[4] = d;
        if (r) n[5] = 1'b1; else if (!e) n[5] = d;
        return n;
    endfunction

    always @(negedge C) begin
        bank   <= bank_nx(bank, LE, LR, LD, fault == 2'd2);
        bank_s <= bank_nx(bank_s, LE_s, LR_s, LD_s, 1'b0);
    end

    assign Q_i = (fault == 2'd1) ? (bank & 6'b110111) : bank;
    assign Q_s = ~bank_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge C);
        #1;
    endtask

    task automatic wait_done(input int limit);
        while (!done && cyc < limit) begin
            step();
            cyc++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
    endtask

    initial begin
        // reset state
        step();
        step();
        R = 1'b0;
        chk("rst_drive", 32'({LE, LR, LD}), 32'h2);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_pass", 32'(pass), 32'h0);
        chk("rst_err", 32'(err_count), 32'h0);
        chk("rst_ffi", 32'(first_fail_idx), 32'h0);
        chk("rst_ffq", 32'(first_fail_q), 32'h0);

        // ideal bank: drive sequence, timing, pass
        pulse_start();
        chk("init1_drive", 32'({LE, LR, LD}), 32'h2);
        chk("init1_busy", 32'(busy), 32'h1);
        step(); cyc++;
        chk("init2_drive", 32'({LE, LR, LD}), 32'h4);
        step(); cyc++;
        chk("run_vec1", 32'({LE, LR, LD}), 32'h1);
        step(); cyc++;
        chk("run_vec2", 32'({LE, LR, LD}), 32'h3);
        step(); cyc++;
        chk("run_vec3", 32'({LE, LR, LD}), 32'h7);
        wait_done(200);
        chk("ideal_done", 32'(done), 32'h1);
        chk("ideal_cycles", 32'(cyc), 32'd66);
        chk("ideal_pass", 32'(pass), 32'h1);
        chk("ideal_err", 32'(err_count), 32'h0);
        chk("ideal_busy", 32'(busy), 32'h0);
        chk("done_drive", 32'({LE, LR, LD}), 32'h2);

        // PP1 stuck at 0: caught at the INIT1 compare
        fault = 2'd1;
        pulse_start();
        chk("pp1_clear", 32'(err_count), 32'h0);
        step(); cyc++;
        chk("pp1_init1_err", 32'(err_count), 32'h1);
        wait_done(200);
        chk("pp1_done", 32'(done), 32'h1);
        chk("pp1_pass", 32'(pass), 32'h0);
        chk("pp1_err_nz", 32'(err_count != 8'd0), 32'h1);
        chk("pp1_ffi", 32'(first_fail_idx), 32'h0);
`ifdef LATCH_SEQ_ERRLOG_EN
        chk("pp1_ffq3", 32'(first_fail_q[3]), 32'h0);
`else
        chk("pp1_ffq", 32'(first_fail_q), 32'h0);
`endif

        // PN0 reset polarity inverted: first divergence on RUN vector {1,1,1}, index 4
        fault = 2'd2;
        pulse_start();
        wait_done(200);
        chk("pn0_done", 32'(done), 32'h1);
        chk("pn0_pass", 32'(pass), 32'h0);
        chk("pn0_err_nz", 32'(err_count != 8'd0), 32'h1);
`ifdef LATCH_SEQ_ERRLOG_EN
        chk("pn0_ffi", 32'(first_fail_idx), 32'd4);
        chk("pn0_ffq", 32'(first_fail_q), 32'h38);
`else
        chk("pn0_ffi", 32'(first_fail_idx), 32'h0);
`endif

        // R mid-run discards the partial result
        fault = 2'd1;
        pulse_start();
        repeat (10) begin step(); cyc++; end
        chk("midrun_err", 32'(err_count != 8'd0), 32'h1);
        chk("midrun_busy", 32'(busy), 32'h1);
        R = 1'b1;
        step();
        R = 1'b0;
        chk("r_busy", 32'(busy), 32'h0);
        chk("r_done", 32'(done), 32'h0);
        chk("r_lr", 32'(LR), 32'h1);
        chk("r_err", 32'(err_count), 32'h0);
        fault = 2'd0;
        pulse_start();
        wait_done(200);
        chk("after_r_cycles", 32'(cyc), 32'd66);
        chk("after_r_pass", 32'(pass), 32'h1);

        // start held high: single run, then immediate re-trigger at DONE
        fault = 2'd1;
        start = 1'b1;
        step();
        cyc = 0;
        wait_done(200);
        chk("held_cycles", 32'(cyc), 32'd66);
        chk("held_err_nz", 32'(err_count != 8'd0), 32'h1);
        chk("held_pass", 32'(pass), 32'h0);
        fault = 2'd0;
        step();
        start = 1'b0;
        cyc = 0;
        chk("retrig_done", 32'(done), 32'h0);
        chk("retrig_busy", 32'(busy), 32'h1);
        chk("retrig_err", 32'(err_count), 32'h0);
        wait_done(200);
        chk("retrig_cycles", 32'(cyc), 32'd66);
        chk("retrig_pass", 32'(pass), 32'h1);

        // always-mismatching bank with 300 vectors saturates the counter
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        cyc = 0;
        while (!done_s && cyc < 400) begin
            step();
            cyc++;
        end
        chk("sat_cycles", 32'(cyc), 32'd302);
        chk("sat_err", 32'(err_s), 32'd255);
        chk("sat_pass", 32'(pass_s), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
